// File: rtl/mips_mem_pkg.sv
// Shared constants for the unified memory port arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state encodings, requester IDs and default bus widths.
package mips_mem_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

    // FSM state encodings.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_IWAIT = 2'd1;
    localparam logic [1:0] ST_DWAIT = 2'd2;

    // Requester IDs.
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/arb_streak_ctr.sv
// Saturating streak counter; raises o_flip once the high-priority side has won MAX_STREAK times in a row over a waiting low side.
// Latency: o_flip is a registered compare, valid the cycle after the grant that completes the streak.
// Backpressure: none; it only observes grants.
//
// Ports:
//   clk, reset : clock, async active-high reset
//   i_win_hi   : high-priority requester granted this cycle
//   i_lo_pend  : low-priority requester is waiting
//   i_win_lo   : low-priority requester granted this cycle
//   o_flip     : streak exhausted, low side must win the next contest
module arb_streak_ctr #(
    parameter int MAX_STREAK = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_win_hi,
    input  logic i_lo_pend,
    input  logic i_win_lo,
    output logic o_flip
);

    localparam int              SW   = $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0]   SMAX = SW'(MAX_STREAK);

    logic [SW-1:0] r_streak;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_streak <= '0;
        end else if (i_win_hi) begin
            // Only wins that starve a waiting low side count toward the streak.
            if (!i_lo_pend)
                r_streak <= '0;
            else if (r_streak != SMAX)
                r_streak <= r_streak + 1'b1;
        end else if (i_win_lo) begin
            r_streak <= '0;
        end
    end

    assign o_flip = (r_streak == SMAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port memory between the instruction-fetch port and the data port, with data priority.
// Latency: grant edge -> mem_req; ack in the first wait cycle yields done 2 cycles after the grant cycle.
// Backpressure: requesters hold req until their one-cycle done pulse; a watchdog aborts accesses that never get mem_ack.
//
// Ports:
//   clk, reset                                    : clock, async active-high reset
//   if_req/if_addr -> if_rdata/if_done            : fetch port
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_done   : load/store port
//   mem_req/mem_we/mem_addr/mem_wdata, mem_rdata/mem_ack : memory side
//   busy                                          : transaction outstanding
//   err                                           : sticky timeout flag
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 64,
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          busy,
    output logic          err
);

    localparam int            TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [1:0]    r_state;
    logic [TW-1:0] r_tmo;
    logic          r_mem_req, r_mem_we, r_busy, r_err, r_if_done, r_d_done;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata, r_if_rdata, r_d_rdata;

    logic w_idle, w_flip, w_grant_d, w_grant_i, w_winner;

    assign w_idle    = (r_state == ST_IDLE);
    // Data wins every contest unless fetch has been starved for a full streak.
    assign w_grant_d = w_idle && d_req && !(if_req && w_flip);
    assign w_grant_i = w_idle && if_req && !w_grant_d;
    assign w_winner  = w_grant_d ? REQ_D : REQ_IF;

    arb_streak_ctr #(.MAX_STREAK(MAX_STREAK)) u_streak (
        .clk       (clk),
        .reset     (reset),
        .i_win_hi  (w_grant_d),
        .i_lo_pend (if_req),
        .i_win_lo  (w_grant_i),
        .o_flip    (w_flip)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_tmo       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_done   <= 1'b0;
            r_d_done    <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_if_done <= 1'b0;
            r_d_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tmo <= '0;
                    if (w_grant_d || w_grant_i) begin
                        r_state     <= (w_winner == REQ_D) ? ST_DWAIT : ST_IWAIT;
                        r_mem_req   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_mem_we    <= (w_winner == REQ_D) ? d_we    : 1'b0;
                        r_mem_addr  <= (w_winner == REQ_D) ? d_addr  : if_addr;
                        r_mem_wdata <= (w_winner == REQ_D) ? d_wdata : '0;
                    end
                end
                ST_IWAIT, ST_DWAIT: begin
                    // Ack has precedence over the watchdog in the abort cycle.
                    if (mem_ack || (r_tmo == TMO_LAST)) begin
                        r_state   <= ST_IDLE;
                        r_mem_req <= 1'b0;
                        r_busy    <= 1'b0;
                        r_if_done <= (r_state == ST_IWAIT);
                        r_d_done  <= (r_state == ST_DWAIT);
                        if (!mem_ack)
                            r_err <= 1'b1;
                        else if (r_state == ST_IWAIT)
                            r_if_rdata <= mem_rdata;
                        else if (!r_mem_we)
                            r_d_rdata <= mem_rdata;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign if_done   = r_if_done;
    assign d_rdata   = r_d_rdata;
    assign d_done    = r_d_done;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule
